// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes, controller states and width helper
package traffic_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;
  localparam logic [1:0] LIGHT_OFF    = 2'b11;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  // Bits needed to index n values, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides CLK down to a one-cycle tick enable
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int CLK_HZ  = 16000000,
  parameter int TICK_HZ = 1
) (
  input  logic CLK,
  input  logic reset_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/traffic_ctrl_n.sv
// rtl/traffic_ctrl_n.sv - N-way demand-driven traffic-light controller with night flash
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int N_WAYS    = 2,
  parameter int CLK_HZ    = 16000000,
  parameter int TICK_HZ   = 1,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  localparam int AW       = clog2(N_WAYS)
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic [N_WAYS-1:0]     sensor,
  input  logic                  night,
  output logic [2*N_WAYS-1:0]   light,
  output logic [AW-1:0]         active_way,
  output logic                  tick
);

  localparam int TMAX_A = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int TMAX   = (TMAX_A > ALLRED_T) ? TMAX_A : ALLRED_T;
  localparam int TW     = clog2(TMAX + 1);
  localparam logic [TW-1:0] T_GMIN   = TW'(GREEN_MIN);
  localparam logic [TW-1:0] T_GMAX   = TW'(GREEN_MAX);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T);

  logic [N_WAYS-1:0]   sens_meta_q, sens_q;
  logic                night_meta_q, night_q;
  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d, timer_inc;
  logic [AW-1:0]       active_q, active_d, next_way;
  logic                first_q, first_d;
  logic                lit_q, lit_d;
  logic [2*N_WAYS-1:0] light_q, light_d;
  logic                other, own;

  tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_prescaler (
    .CLK     (CLK),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sens_meta_q  <= '0;
      sens_q       <= '0;
      night_meta_q <= 1'b0;
      night_q      <= 1'b0;
    end else begin
      sens_meta_q  <= sensor;
      sens_q       <= sens_meta_q;
      night_meta_q <= night;
      night_q      <= night_meta_q;
    end
  end

  // Round-robin search for the next demanded way after the current owner.
  always_comb begin
    int idx;
    next_way = (int'(active_q) == N_WAYS - 1) ? '0 : active_q + AW'(1);
    for (int k = N_WAYS - 1; k >= 1; k--) begin
      idx = int'(active_q) + k;
      if (idx >= N_WAYS) idx = idx - N_WAYS;
      if (sens_q[idx]) next_way = AW'(idx);
    end
    if (first_q) next_way = '0;
  end

  always_comb begin
    other = 1'b0;
    for (int j = 0; j < N_WAYS; j++) begin
      if (j != int'(active_q) && sens_q[j]) other = 1'b1;
    end
    own       = sens_q[active_q];
    timer_inc = (timer_q == T_GMAX) ? timer_q : timer_q + TW'(1);
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    active_d = active_q;
    first_d  = first_q;
    lit_d    = lit_q;
    if (tick) begin
      timer_d = timer_inc;
      unique case (state_q)
        ST_ALLRED: begin
          if (timer_inc >= T_ALLRED) begin
            timer_d = '0;
            if (night_q) begin
              state_d = ST_FLASH;
              lit_d   = 1'b1;
            end else begin
              state_d  = ST_GREEN;
              active_d = next_way;
              first_d  = 1'b0;
            end
          end
        end
        ST_GREEN: begin
          if ((timer_inc >= T_GMIN && (night_q || (!own && other))) ||
              (timer_inc == T_GMAX && other)) begin
            state_d = ST_YELLOW;
            timer_d = '0;
          end
        end
        ST_YELLOW: begin
          if (timer_inc >= T_YELLOW) begin
            state_d = ST_ALLRED;
            timer_d = '0;
          end
        end
        ST_FLASH: begin
          // Leaving flash restarts the rotation at way 0.
          if (!night_q) begin
            state_d  = ST_ALLRED;
            timer_d  = '0;
            active_d = '0;
            first_d  = 1'b1;
          end else begin
            lit_d = ~lit_q;
          end
        end
        default: state_d = ST_ALLRED;
      endcase
    end
  end

  always_comb begin
    light_d = {N_WAYS{LIGHT_RED}};
    for (int i = 0; i < N_WAYS; i++) begin
      case (state_d)
        ST_GREEN:  if (AW'(i) == active_d) light_d[2*i +: 2] = LIGHT_GREEN;
        ST_YELLOW: if (AW'(i) == active_d) light_d[2*i +: 2] = LIGHT_YELLOW;
        ST_FLASH:  light_d[2*i +: 2] = !lit_d ? LIGHT_OFF :
                                       (i == 0) ? LIGHT_YELLOW : LIGHT_RED;
        default:   light_d[2*i +: 2] = LIGHT_RED;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ALLRED;
      timer_q  <= '0;
      active_q <= '0;
      first_q  <= 1'b1;
      lit_q    <= 1'b0;
      light_q  <= {N_WAYS{LIGHT_RED}};
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      first_q  <= first_d;
      lit_q    <= lit_d;
      light_q  <= light_d;
    end
  end

  assign light      = light_q;
  assign active_way = active_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// tb/tb_traffic_ctrl_n.sv - directed self-checking bench for traffic_ctrl_n
module tb_traffic_ctrl_n;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] sensor = 2'b00;
  logic       night = 1'b0;
  logic [3:0] light;
  logic [0:0] active_way;
  logic       tick;

  int   n_checks = 0;
  int   n_errors = 0;
  logic inv_en = 1'b0;

  always #5 CLK = ~CLK;

  traffic_ctrl_n #(
    .N_WAYS(2), .CLK_HZ(8), .TICK_HZ(1),
    .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1)
  ) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .sensor     (sensor),
    .night      (night),
    .light      (light),
    .active_way (active_way),
    .tick       (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nonred(input logic [3:0] l);
    int c;
    c = 0;
    for (int i = 0; i < 2; i++) if (l[2*i +: 2] != 2'b10) c++;
    return c;
  endfunction

  always @(negedge CLK) begin
    if (inv_en && reset_n) check("one_nonred", 32'(nonred(light) <= 1), 32'd1);
  end

  // Returns one cycle after the next tick, when the registered light has updated.
  task automatic next_tick();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!tick && n < 20);
    if (!tick) check("tick_seen", 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  task automatic do_reset(input logic [1:0] s, input logic n);
    @(negedge CLK);
    reset_n = 1'b0;
    sensor  = s;
    night   = n;
    repeat (3) @(negedge CLK);
    check("rst_light", light, 4'b1010);
    reset_n = 1'b1;
  endtask

  task automatic run_seq(input string tag, input logic [3:0] seq[$]);
    foreach (seq[i]) begin
      next_tick();
      check(tag, light, seq[i]);
    end
  endtask

  initial begin
    logic [3:0] seq[$];
    int n;

    // 1: reset state, first green, tick spacing, green held without demand
    repeat (3) @(negedge CLK);
    check("s1_rst_light", light, 4'b1010);
    check("s1_rst_active", active_way, 1'b0);
    check("s1_rst_tick", tick, 1'b0);
    reset_n = 1'b1;
    inv_en  = 1'b1;
    next_tick();
    check("s1_green0", light, 4'b1000);
    check("s1_active0", active_way, 1'b0);
    check("s1_tick_pulse", tick, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!tick && n < 20);
    check("s1_tick_period", n, 7);
    @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      next_tick();
      check("s1_stay_green", light, 4'b1000);
    end

    // 2: demand on way 1 only
    do_reset(2'b10, 1'b0);
    seq = '{4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1010, 4'b0010};
    run_seq("s2_seq", seq);
    check("s2_active1", active_way, 1'b1);

    // 3: both demanded, max-green rotation 6/2/1
    do_reset(2'b11, 1'b0);
    seq = {};
    repeat (6) seq.push_back(4'b1000);
    repeat (2) seq.push_back(4'b1001);
    seq.push_back(4'b1010);
    repeat (6) seq.push_back(4'b0010);
    repeat (2) seq.push_back(4'b0110);
    seq.push_back(4'b1010);
    run_seq("s3_seq", seq);
    check("s3_active1", active_way, 1'b1);
    next_tick();
    check("s3_back_way0", light, 4'b1000);
    check("s3_active0", active_way, 1'b0);

    // 4: night mode entry, flash, exit to way 0
    do_reset(2'b00, 1'b0);
    next_tick();
    check("s4_green0", light, 4'b1000);
    inv_en = 1'b0;
    night  = 1'b1;
    seq = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1010, 4'b1001, 4'b1111, 4'b1001};
    run_seq("s4_seq", seq);
    night = 1'b0;
    next_tick();
    check("s4_exit_allred", light, 4'b1010);
    check("s4_exit_active", active_way, 1'b0);
    next_tick();
    check("s4_green0_again", light, 4'b1000);
    check("s4_active0_again", active_way, 1'b0);
    inv_en = 1'b1;

    // 5: asynchronous reset mid-yellow, away from the tick edge
    do_reset(2'b10, 1'b0);
    seq = '{4'b1000, 4'b1000, 4'b1000, 4'b1001};
    run_seq("s5_pre", seq);
    check("s5_active_pre", active_way, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    #2;
    reset_n = 1'b0;
    sensor  = 2'b00;
    #1;
    check("s5_async_light", light, 4'b1010);
    check("s5_async_active", active_way, 1'b0);
    check("s5_async_tick", tick, 1'b0);
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;
    next_tick();
    check("s5_restart_green", light, 4'b1000);
    check("s5_restart_active", active_way, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_tick();
      check("s5_restart_stay", light, 4'b1000);
    end

    // 6: one-cycle sensor glitch between ticks is ignored
    do_reset(2'b00, 1'b0);
    next_tick();
    check("s6_green0", light, 4'b1000);
    @(negedge CLK);
    sensor = 2'b10;
    @(negedge CLK);
    sensor = 2'b00;
    for (int i = 0; i < 6; i++) begin
      next_tick();
      check("s6_no_change", light, 4'b1000);
    end
    check("s6_active", active_way, 1'b0);

    inv_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
